// File: rtl/mem_lsu_wb.sv
// mem_lsu_wb: load/store unit and MEM/WB pipeline register for the MIPS core.
//
// A memory op presented in IDLE raises stall, and its request fields are
// captured into registers as the FSM enters WAIT. The handshaked data-memory
// port (dmem_req held until dmem_ack) then completes the access. On ack the
// op retires into the MEM/WB register. After TIMEOUT unacked WAIT cycles the
// access is abandoned: bus_err pulses and a bubble retires. Branch resolution
// (pc_src) is combinational from the live EX/MEM fields.
//
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses are trapped, pulse misalign_err and retire as bubbles.
// When it is undefined, low address bits are ignored and misalign_err is tied 0.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   in_addr_mem          - ALU result / byte address
//   write_data           - store data
//   memory_bus           - [0]MemWrite [1]MemRead [2]Branch [3]unsigned
//                          [4]LH [5]LB [6]SH [7]SB [8]BranchNotEqual
//   in_writeBack_bus, in_write_reg, halt_flag_m - WB controls from EX/MEM
//   zero_flag, in_pc_branch                     - branch inputs
//   dmem_req/we/addr/wdata/be, dmem_rdata/ack   - data-memory port
//   stall                - freezes upstream pipeline stages
//   pc_src, out_pc_branch                       - branch outputs
//   read_data, out_addr_mem, out_writeBack_bus, out_write_reg,
//   out_halt_flag_m      - registered MEM/WB outputs
//   bus_err, misalign_err - one-cycle error pulses
module mem_lsu_wb #(
  parameter int LEN_DATA    = 32,
  parameter int NUM_BITS    = 5,
  parameter int ADDR_W      = 11,
  parameter int LEN_MEM_BUS = 9,
  parameter int LEN_WB_BUS  = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LEN_DATA-1:0]    in_addr_mem,
  input  logic [LEN_DATA-1:0]    write_data,
  input  logic [LEN_MEM_BUS-1:0] memory_bus,
  input  logic [LEN_WB_BUS-1:0]  in_writeBack_bus,
  input  logic [NUM_BITS-1:0]    in_write_reg,
  input  logic                   zero_flag,
  input  logic [LEN_DATA-1:0]    in_pc_branch,
  input  logic                   halt_flag_m,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ADDR_W-1:0]      dmem_addr,
  output logic [LEN_DATA-1:0]    dmem_wdata,
  output logic [3:0]             dmem_be,
  input  logic [LEN_DATA-1:0]    dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   stall,
  output logic                   pc_src,
  output logic [LEN_DATA-1:0]    out_pc_branch,
  output logic [LEN_DATA-1:0]    read_data,
  output logic [LEN_DATA-1:0]    out_addr_mem,
  output logic [LEN_WB_BUS-1:0]  out_writeBack_bus,
  output logic [NUM_BITS-1:0]    out_write_reg,
  output logic                   out_halt_flag_m,
  output logic                   bus_err,
  output logic                   misalign_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  function automatic logic [LEN_DATA-1:0] load_extract(input logic [LEN_DATA-1:0] w,
                                                       input logic [1:0] off,
                                                       input logic b, input logic h,
                                                       input logic u);
    logic [7:0]  by;
    logic [15:0] hw;
    by = w[{off, 3'b000} +: 8];
    hw = off[1] ? w[31:16] : w[15:0];
    if (b)      return u ? {{(LEN_DATA-8){1'b0}}, by}  : {{(LEN_DATA-8){by[7]}}, by};
    else if (h) return u ? {{(LEN_DATA-16){1'b0}}, hw} : {{(LEN_DATA-16){hw[15]}}, hw};
    else        return w;
  endfunction

  // Decode; the width selects come from different bus bits for loads and stores.
  logic mem_wr, mem_rd, mem_op, ld_uns, is_byte, is_half, trap_c;
  assign mem_wr  = memory_bus[0];
  assign mem_rd  = memory_bus[1];
  assign mem_op  = mem_wr | mem_rd;
  assign ld_uns  = memory_bus[3];
  assign is_byte = mem_wr ? memory_bus[7] : memory_bus[5];
  assign is_half = ~is_byte & (mem_wr ? memory_bus[6] : memory_bus[4]);

`ifdef MISALIGN_TRAP_EN
  assign trap_c = mem_op & ((is_half & in_addr_mem[0]) |
                            (~is_byte & ~is_half & (in_addr_mem[1:0] != 2'b00)));
`else
  assign trap_c = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]     dmem_addr_q, dmem_addr_d;
  logic [LEN_DATA-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]            dmem_be_q, dmem_be_d;
  // Captured request fields, used when the op retires on ack.
  logic                  rq_uns_q, rq_uns_d, rq_byte_q, rq_byte_d, rq_half_q, rq_half_d;
  logic [LEN_DATA-1:0]   rq_addr_q, rq_addr_d;
  logic [LEN_WB_BUS-1:0] rq_wb_q, rq_wb_d;
  logic [NUM_BITS-1:0]   rq_reg_q, rq_reg_d;
  logic                  rq_halt_q, rq_halt_d;
  // MEM/WB register.
  logic [LEN_DATA-1:0]   read_data_q, read_data_d, addr_mem_q, addr_mem_d;
  logic [LEN_WB_BUS-1:0] wb_q, wb_d;
  logic [NUM_BITS-1:0]   wreg_q, wreg_d;
  logic                  halt_q, halt_d, bus_err_q, bus_err_d;

  logic issue, wait_st, tmo_c;
  assign issue   = (state_q == S_IDLE) & mem_op & ~trap_c;
  assign wait_st = (state_q == S_WAIT);
  // Last unacked WAIT cycle: leave WAIT without asserting stall.
  assign tmo_c   = wait_st & ~dmem_ack & (cnt_q == CNT_LAST);
  assign stall   = issue | (wait_st & ~dmem_ack & ~tmo_c);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    rq_uns_d     = rq_uns_q;
    rq_byte_d    = rq_byte_q;
    rq_half_d    = rq_half_q;
    rq_addr_d    = rq_addr_q;
    rq_wb_d      = rq_wb_q;
    rq_reg_d     = rq_reg_q;
    rq_halt_d    = rq_halt_q;
    read_data_d  = read_data_q;
    addr_mem_d   = addr_mem_q;
    // Bubble unless an op retires this cycle.
    wb_d         = '0;
    wreg_d       = '0;
    halt_d       = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d      = S_WAIT;
          cnt_d        = 8'd0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_wr;
          dmem_addr_d  = in_addr_mem[ADDR_W+1:2];
          if (mem_wr && is_byte) begin
            dmem_be_d    = 4'b0001 << in_addr_mem[1:0];
            dmem_wdata_d = {4{write_data[7:0]}};
          end else if (mem_wr && is_half) begin
            dmem_be_d    = 4'b0011 << {in_addr_mem[1], 1'b0};
            dmem_wdata_d = {2{write_data[15:0]}};
          end else begin
            dmem_be_d    = 4'b1111;
            dmem_wdata_d = write_data;
          end
          rq_uns_d  = ld_uns;
          rq_byte_d = is_byte;
          rq_half_d = is_half;
          rq_addr_d = in_addr_mem;
          rq_wb_d   = in_writeBack_bus;
          rq_reg_d  = in_write_reg;
          rq_halt_d = halt_flag_m;
        end else if (!mem_op) begin
          read_data_d = load_extract(dmem_rdata, in_addr_mem[1:0], is_byte, is_half, ld_uns);
          addr_mem_d  = in_addr_mem;
          wb_d        = in_writeBack_bus;
          wreg_d      = in_write_reg;
          halt_d      = halt_flag_m;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d     = S_IDLE;
          cnt_d       = 8'd0;
          dmem_req_d  = 1'b0;
          read_data_d = load_extract(dmem_rdata, rq_addr_q[1:0], rq_byte_q, rq_half_q, rq_uns_q);
          addr_mem_d  = rq_addr_q;
          wb_d        = rq_wb_q;
          wreg_d      = rq_reg_q;
          halt_d      = rq_halt_q;
        end else if (tmo_c) begin
          state_d    = S_IDLE;
          cnt_d      = 8'd0;
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      rq_uns_q     <= 1'b0;
      rq_byte_q    <= 1'b0;
      rq_half_q    <= 1'b0;
      rq_addr_q    <= '0;
      rq_wb_q      <= '0;
      rq_reg_q     <= '0;
      rq_halt_q    <= 1'b0;
      read_data_q  <= '0;
      addr_mem_q   <= '0;
      wb_q         <= '0;
      wreg_q       <= '0;
      halt_q       <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      rq_uns_q     <= rq_uns_d;
      rq_byte_q    <= rq_byte_d;
      rq_half_q    <= rq_half_d;
      rq_addr_q    <= rq_addr_d;
      rq_wb_q      <= rq_wb_d;
      rq_reg_q     <= rq_reg_d;
      rq_halt_q    <= rq_halt_d;
      read_data_q  <= read_data_d;
      addr_mem_q   <= addr_mem_d;
      wb_q         <= wb_d;
      wreg_q       <= wreg_d;
      halt_q       <= halt_d;
      bus_err_q    <= bus_err_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_err_q, misalign_err_d;
  assign misalign_err_d = trap_c & (state_q == S_IDLE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_err_q <= 1'b0;
    else       misalign_err_q <= misalign_err_d;
  end
  assign misalign_err = misalign_err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign dmem_req          = dmem_req_q;
  assign dmem_we           = dmem_we_q;
  assign dmem_addr         = dmem_addr_q;
  assign dmem_wdata        = dmem_wdata_q;
  assign dmem_be           = dmem_be_q;
  assign read_data         = read_data_q;
  assign out_addr_mem      = addr_mem_q;
  assign out_writeBack_bus = wb_q;
  assign out_write_reg     = wreg_q;
  assign out_halt_flag_m   = halt_q;
  assign bus_err           = bus_err_q;
  assign pc_src            = memory_bus[2] & (memory_bus[8] ? ~zero_flag : zero_flag);
  assign out_pc_branch     = in_pc_branch;

endmodule

// File: tb/tb_mem_lsu_wb.sv
module tb_mem_lsu_wb;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_addr_mem, write_data, in_pc_branch, dmem_rdata;
  logic [8:0]  memory_bus;
  logic [1:0]  in_writeBack_bus;
  logic [4:0]  in_write_reg;
  logic        zero_flag, halt_flag_m, dmem_ack;
  logic        dmem_req, dmem_we, stall, pc_src, out_halt_flag_m, bus_err, misalign_err;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata, out_pc_branch, read_data, out_addr_mem;
  logic [3:0]  dmem_be;
  logic [1:0]  out_writeBack_bus;
  logic [4:0]  out_write_reg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu_wb #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_addr_mem(in_addr_mem), .write_data(write_data),
    .memory_bus(memory_bus), .in_writeBack_bus(in_writeBack_bus), .in_write_reg(in_write_reg),
    .zero_flag(zero_flag), .in_pc_branch(in_pc_branch), .halt_flag_m(halt_flag_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .pc_src(pc_src), .out_pc_branch(out_pc_branch), .read_data(read_data),
    .out_addr_mem(out_addr_mem), .out_writeBack_bus(out_writeBack_bus),
    .out_write_reg(out_write_reg), .out_halt_flag_m(out_halt_flag_m),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    in_addr_mem = '0; write_data = '0; memory_bus = '0; in_writeBack_bus = '0;
    in_write_reg = '0; zero_flag = 1'b0; in_pc_branch = '0; halt_flag_m = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] wd, input logic [8:0] bus,
                        input logic [1:0] wb, input logic [4:0] rd);
    in_addr_mem = a; write_data = wd; memory_bus = bus; in_writeBack_bus = wb;
    in_write_reg = rd; dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_nop();
    dmem_rdata = '0;
    repeat (2) tick();
    checks++; if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin failures++; $display("FAIL rst_req_we_be got=%b want=0", {dmem_req, dmem_we, dmem_be}); end
    checks++; if (dmem_addr !== 11'd0) begin failures++; $display("FAIL rst_addr got=%h want=0", dmem_addr); end
    checks++; if (dmem_wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h want=0", dmem_wdata); end
    checks++; if ({read_data, out_addr_mem} !== 64'd0) begin failures++; $display("FAIL rst_data got=%h want=0", {read_data, out_addr_mem}); end
    checks++; if ({out_writeBack_bus, out_write_reg, out_halt_flag_m} !== 8'd0) begin failures++; $display("FAIL rst_wb got=%h want=0", {out_writeBack_bus, out_write_reg, out_halt_flag_m}); end
    checks++; if ({bus_err, misalign_err, stall} !== 3'b0) begin failures++; $display("FAIL rst_err_stall got=%b want=000", {bus_err, misalign_err, stall}); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    set_op(32'h1234_5678, 32'h0, 9'h000, 2'b11, 5'd7);
    halt_flag_m = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b want=0", stall); end
    tick();
    set_op(32'hCAFE_F00D, 32'h0, 9'h000, 2'b10, 5'd12);
    halt_flag_m = 1'b0;
    checks++; if (out_addr_mem !== 32'h1234_5678) begin failures++; $display("FAIL alu1_addr got=%h want=12345678", out_addr_mem); end
    checks++; if ({out_writeBack_bus, out_write_reg, out_halt_flag_m} !== {2'b11, 5'd7, 1'b1}) begin failures++; $display("FAIL alu1_wb got=%h want=%h", {out_writeBack_bus, out_write_reg, out_halt_flag_m}, {2'b11, 5'd7, 1'b1}); end
    tick();
    set_nop();
    checks++; if (out_addr_mem !== 32'hCAFE_F00D) begin failures++; $display("FAIL alu2_addr got=%h want=cafef00d", out_addr_mem); end
    checks++; if ({out_writeBack_bus, out_write_reg, out_halt_flag_m} !== {2'b10, 5'd12, 1'b0}) begin failures++; $display("FAIL alu2_wb got=%h want=%h", {out_writeBack_bus, out_write_reg, out_halt_flag_m}, {2'b10, 5'd12, 1'b0}); end
    tick();
  endtask

  task automatic test_store();
    // SB 0xA5 to byte address 6
    set_op(32'h6, 32'h0000_00A5, 9'h081, 2'b00, 5'd0);
    #1;
    checks++; if ({stall, dmem_req} !== 2'b10) begin failures++; $display("FAIL sb_issue got=%b want=10", {stall, dmem_req}); end
    tick();
    checks++; if ({dmem_req, dmem_we, dmem_be} !== 6'b11_0100) begin failures++; $display("FAIL sb_req_we_be got=%b want=110100", {dmem_req, dmem_we, dmem_be}); end
    checks++; if (dmem_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", dmem_wdata); end
    checks++; if (dmem_addr !== 11'd1) begin failures++; $display("FAIL sb_addr got=%h want=1", dmem_addr); end
    dmem_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_ack_stall got=%b want=0", stall); end
    tick();
    set_nop();
    #1;
    checks++; if ({dmem_req, stall} !== 2'b00) begin failures++; $display("FAIL sb_done got=%b want=00", {dmem_req, stall}); end
    // SH 0xBEEF to byte address 2
    set_op(32'h2, 32'h0000_BEEF, 9'h041, 2'b00, 5'd0);
    tick();
    checks++; if (dmem_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b want=1100", dmem_be); end
    checks++; if (dmem_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h want=beefbeef", dmem_wdata); end
    dmem_ack = 1'b1;
    tick();
    set_nop();
  endtask

  task automatic test_load_extract();
    // LH signed at 0x2
    set_op(32'h2, 32'h0, 9'h012, 2'b11, 5'd5);
    tick();
    dmem_rdata = 32'h8001_1234;
    dmem_ack = 1'b1;
    #1;
    checks++; if ({dmem_we, dmem_be} !== 5'b0_1111) begin failures++; $display("FAIL lh_we_be got=%b want=01111", {dmem_we, dmem_be}); end
    tick();
    set_nop();
    checks++; if (read_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_signed got=%h want=ffff8001", read_data); end
    checks++; if ({out_writeBack_bus, out_write_reg} !== {2'b11, 5'd5}) begin failures++; $display("FAIL lh_wb got=%h want=%h", {out_writeBack_bus, out_write_reg}, {2'b11, 5'd5}); end
    // LHU at 0x2
    set_op(32'h2, 32'h0, 9'h01A, 2'b11, 5'd5);
    tick();
    dmem_ack = 1'b1;
    tick();
    set_nop();
    checks++; if (read_data !== 32'h0000_8001) begin failures++; $display("FAIL lh_unsigned got=%h want=00008001", read_data); end
    // LB signed at 0x5 (lane 1)
    set_op(32'h5, 32'h0, 9'h022, 2'b01, 5'd8);
    tick();
    checks++; if (dmem_addr !== 11'd1) begin failures++; $display("FAIL lb_addr got=%h want=1", dmem_addr); end
    dmem_rdata = 32'h0000_F700;
    dmem_ack = 1'b1;
    tick();
    set_nop();
    checks++; if (read_data !== 32'hFFFF_FFF7) begin failures++; $display("FAIL lb_signed got=%h want=fffffff7", read_data); end
  endtask

  task automatic test_lw_wait();
    set_op(32'h10, 32'h0, 9'h002, 2'b01, 5'd9);
    dmem_rdata = 32'h0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall_%0d got=%b want=1", i, stall); end
      tick();
      checks++; if ({out_writeBack_bus, out_write_reg} !== 7'd0) begin failures++; $display("FAIL lw_bubble_%0d got=%h want=0", i, {out_writeBack_bus, out_write_reg}); end
    end
    checks++; if (dmem_addr !== 11'd4) begin failures++; $display("FAIL lw_addr got=%h want=4", dmem_addr); end
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lw_ack_stall got=%b want=0", stall); end
    tick();
    set_nop();
    checks++; if (read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h want=deadbeef", read_data); end
    checks++; if ({out_writeBack_bus, out_write_reg} !== {2'b01, 5'd9}) begin failures++; $display("FAIL lw_wb got=%h want=%h", {out_writeBack_bus, out_write_reg}, {2'b01, 5'd9}); end
    tick();
    checks++; if (out_write_reg !== 5'd0) begin failures++; $display("FAIL lw_wb_once got=%h want=0", out_write_reg); end
  endtask

  task automatic test_timeout();
    set_op(32'h20, 32'h0, 9'h002, 2'b01, 5'd3);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL to_stall_%0d got=%b want=1", i, stall); end
      tick();
    end
    checks++; if ({stall, dmem_req, bus_err} !== 3'b010) begin failures++; $display("FAIL to_last got=%b want=010", {stall, dmem_req, bus_err}); end
    tick();
    set_nop();
    #1;
    checks++; if ({bus_err, dmem_req, stall} !== 3'b100) begin failures++; $display("FAIL to_err got=%b want=100", {bus_err, dmem_req, stall}); end
    checks++; if ({out_writeBack_bus, out_write_reg} !== 7'd0) begin failures++; $display("FAIL to_bubble got=%h want=0", {out_writeBack_bus, out_write_reg}); end
    tick();
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b want=0", bus_err); end
  endtask

  task automatic test_misalign();
    set_op(32'h3, 32'h0, 9'h002, 2'b01, 5'd4);
    dmem_rdata = 32'h1122_3344;
    #1;
`ifdef MISALIGN_TRAP_EN
    checks++; if ({stall, dmem_req} !== 2'b00) begin failures++; $display("FAIL mis_trap got=%b want=00", {stall, dmem_req}); end
    tick();
    set_nop();
    checks++; if ({misalign_err, dmem_req} !== 2'b10) begin failures++; $display("FAIL mis_err got=%b want=10", {misalign_err, dmem_req}); end
    checks++; if (out_write_reg !== 5'd0) begin failures++; $display("FAIL mis_bubble got=%h want=0", out_write_reg); end
    tick();
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b want=0", misalign_err); end
`else
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mis_stall got=%b want=1", stall); end
    tick();
    checks++; if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b1111, 11'd0}) begin failures++; $display("FAIL mis_align got=%h want=%h", {dmem_req, dmem_be, dmem_addr}, {1'b1, 4'b1111, 11'd0}); end
    dmem_ack = 1'b1;
    tick();
    set_nop();
    checks++; if ({read_data, out_write_reg} !== {32'h1122_3344, 5'd4}) begin failures++; $display("FAIL mis_data got=%h want=%h", {read_data, out_write_reg}, {32'h1122_3344, 5'd4}); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_tied got=%b want=0", misalign_err); end
`endif
  endtask

  task automatic test_reset_in_wait();
    set_op(32'h40, 32'h5555_AAAA, 9'h001, 2'b01, 5'd6);
    tick();
    checks++; if ({dmem_req, dmem_we} !== 2'b11) begin failures++; $display("FAIL rw_req got=%b want=11", {dmem_req, dmem_we}); end
    reset = 1'b1;
    set_nop();
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== 17'd0) begin failures++; $display("FAIL rw_port got=%h want=0", {dmem_req, dmem_we, dmem_be, dmem_addr}); end
    checks++; if ({dmem_wdata, read_data, out_addr_mem} !== 96'd0) begin failures++; $display("FAIL rw_data got=%h want=0", {dmem_wdata, read_data, out_addr_mem}); end
    checks++; if ({bus_err, misalign_err, stall, out_write_reg} !== 8'd0) begin failures++; $display("FAIL rw_misc got=%h want=0", {bus_err, misalign_err, stall, out_write_reg}); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    // BNE with zero clear is taken; BEQ with zero set is taken
    memory_bus = 9'h104; zero_flag = 1'b0; in_pc_branch = 32'h0000_0400;
    #1;
    checks++; if ({pc_src, stall} !== 2'b10) begin failures++; $display("FAIL bne_taken got=%b want=10", {pc_src, stall}); end
    checks++; if (out_pc_branch !== 32'h0000_0400) begin failures++; $display("FAIL pc_pass got=%h want=00000400", out_pc_branch); end
    zero_flag = 1'b1;
    #1;
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL bne_not got=%b want=0", pc_src); end
    memory_bus = 9'h004;
    #1;
    checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b want=1", pc_src); end
    // A stray ack while idle must not start or retire anything
    set_nop();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checks++; if ({dmem_req, stall, out_write_reg} !== 7'd0) begin failures++; $display("FAIL idle_ack got=%h want=0", {dmem_req, stall, out_write_reg}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_store();
    test_load_extract();
    test_lw_wait();
    test_timeout();
    test_misalign();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
